// File: rtl/simple_ctrl_if.sv
// Bus between the sequencer, the program ROM and the accumulator datapath.
// The master side is the sequencer; the slave side is the ROM/datapath/system.
interface simple_ctrl_if #(
   parameter int PC_W  = 4,
   parameter int RET_W = 8
) ();
   logic             run;
   logic [PC_W-1:0]  pc;
   logic             instr_req;
   logic [5:0]       instruction_wire;
   logic             RF_ce;
   logic [1:0]       RF_addr;
   logic             ALU_ce;
   logic [2:0]       ALU_opcode_wire;
   logic             A_ce;
   logic             A_sel;
   logic             halted;
   logic [RET_W-1:0] retired;

   modport master (
      input  run,
      input  instruction_wire,
      output pc,
      output instr_req,
      output RF_ce,
      output RF_addr,
      output ALU_ce,
      output ALU_opcode_wire,
      output A_ce,
      output A_sel,
      output halted,
      output retired
   );

   modport slave (
      output run,
      output instruction_wire,
      input  pc,
      input  instr_req,
      input  RF_ce,
      input  RF_addr,
      input  ALU_ce,
      input  ALU_opcode_wire,
      input  A_ce,
      input  A_sel,
      input  halted,
      input  retired
   );
endinterface

// File: rtl/simple_ctrl.sv
// Fetch/decode/execute sequencer for the accumulator datapath.
// Every control output is registered and is a pure function of the state and
// IR that will hold during the coming cycle, so outputs never glitch and an
// asynchronous reset clears every enable at once.
module simple_ctrl #(
   parameter int PC_W  = 4,
   parameter int RET_W = 8
) (
   input logic           clk,
   input logic           rst,   // asynchronous, active low
   simple_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

   // Instruction classes
   function automatic logic is_alu(input logic [5:0] ir);
      return ir[5];
   endfunction

   function automatic logic is_lda(input logic [5:0] ir);
      return (ir[5:4] == 2'b01) && !ir[3];
   endfunction

   function automatic logic is_sta(input logic [5:0] ir);
      return (ir[5:4] == 2'b01) && ir[3];
   endfunction

   function automatic logic is_halt(input logic [5:0] ir);
      return (ir[5:4] == 2'b00) && (ir[3:0] == 4'b0001);
   endfunction

   state_t           state_q, state_d;
   logic [5:0]       ir_q, ir_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [RET_W-1:0] retired_q, retired_d;

   logic             instr_req_q, instr_req_d;
   logic             rf_ce_q, rf_ce_d;
   logic [1:0]       rf_addr_q, rf_addr_d;
   logic             alu_ce_q, alu_ce_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             a_ce_q, a_ce_d;
   logic             a_sel_q, a_sel_d;
   logic             halted_q, halted_d;

   // Next state, IR/PC/retired update, then outputs decoded from the next state
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      pc_d      = pc_q;
      retired_d = retired_q;

      case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d    = bus.instruction_wire;
            pc_d    = pc_q + PC_ONE;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_alu(ir_q) || is_lda(ir_q)) begin
               state_d = S_WB;
            end else if (is_halt(ir_q)) begin
               retired_d = retired_q + RET_ONE;
               state_d   = S_HALT;
            end else begin
               // STA and NOP finish here
               retired_d = retired_q + RET_ONE;
               state_d   = bus.run ? S_FETCH : S_IDLE;
            end
         end
         S_WB: begin
            retired_d = retired_q + RET_ONE;
            state_d   = bus.run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      instr_req_d = 1'b0;
      rf_ce_d     = 1'b0;
      rf_addr_d   = 2'b00;
      alu_ce_d    = 1'b0;
      alu_op_d    = 3'b000;
      a_ce_d      = 1'b0;
      a_sel_d     = 1'b0;
      halted_d    = 1'b0;

      case (state_d)
         S_FETCH: begin
            instr_req_d = 1'b1;
         end
         S_EXEC: begin
            if (is_alu(ir_d)) begin
               alu_ce_d  = 1'b1;
               alu_op_d  = ir_d[4:2];
               rf_addr_d = ir_d[1:0];
            end else if (is_lda(ir_d)) begin
               rf_addr_d = ir_d[1:0];
            end else if (is_sta(ir_d)) begin
               rf_ce_d   = 1'b1;
               rf_addr_d = ir_d[1:0];
            end
         end
         S_WB: begin
            // Only ALU ops and LDA reach WB; ALU ops keep their opcode visible
            a_ce_d    = 1'b1;
            a_sel_d   = is_alu(ir_d);
            rf_addr_d = ir_d[1:0];
            if (is_alu(ir_d)) alu_op_d = ir_d[4:2];
         end
         S_HALT: begin
            halted_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State, architectural registers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ir_q        <= 6'b0;
         pc_q        <= '0;
         retired_q   <= '0;
         instr_req_q <= 1'b0;
         rf_ce_q     <= 1'b0;
         rf_addr_q   <= 2'b00;
         alu_ce_q    <= 1'b0;
         alu_op_q    <= 3'b000;
         a_ce_q      <= 1'b0;
         a_sel_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         pc_q        <= pc_d;
         retired_q   <= retired_d;
         instr_req_q <= instr_req_d;
         rf_ce_q     <= rf_ce_d;
         rf_addr_q   <= rf_addr_d;
         alu_ce_q    <= alu_ce_d;
         alu_op_q    <= alu_op_d;
         a_ce_q      <= a_ce_d;
         a_sel_q     <= a_sel_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.pc              = pc_q;
   assign bus.instr_req       = instr_req_q;
   assign bus.RF_ce           = rf_ce_q;
   assign bus.RF_addr         = rf_addr_q;
   assign bus.ALU_ce          = alu_ce_q;
   assign bus.ALU_opcode_wire = alu_op_q;
   assign bus.A_ce            = a_ce_q;
   assign bus.A_sel           = a_sel_q;
   assign bus.halted          = halted_q;
   assign bus.retired         = retired_q;

endmodule

// File: tb/tb_simple_ctrl.sv
// Bench for simple_ctrl: directed scenarios with literal expectations, then
// randomized ROM contents, run toggling and reset pulses, all checked every
// cycle against an instruction-timeline model.
module tb_simple_ctrl;

   localparam int PC_W  = 4;
   localparam int RET_W = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic [5:0] rom [16];

   simple_ctrl_if #(.PC_W(PC_W), .RET_W(RET_W)) bus ();

   simple_ctrl #(.PC_W(PC_W), .RET_W(RET_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program ROM: data valid the cycle after instr_req
   always @(posedge clk) begin
      if (bus.instr_req) bus.instruction_wire <= rom[bus.pc];
   end

   // ---------------- behavioural model ----------------
   // An instruction is a timeline of cycles k = 0..len-1:
   // k0 fetch, k1 decode (IR loads, pc advances), k2 execute, k3 write-back.
   logic            m_busy;
   logic            m_halt;
   logic [3:0]      m_pc;
   logic [7:0]      m_ret;
   logic [5:0]      m_ir;
   int              m_k;

   function automatic int ilen(input logic [5:0] ir);
      if (ir[5]) return 4;
      if (ir[5:4] == 2'b01 && !ir[3]) return 4;
      return 3;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 1'b0;
         m_halt <= 1'b0;
         m_pc   <= 4'd0;
         m_ret  <= 8'd0;
         m_ir   <= 6'd0;
         m_k    <= 0;
      end else if (m_halt) begin
         m_halt <= 1'b1;
      end else if (!m_busy) begin
         if (bus.run) begin
            m_busy <= 1'b1;
            m_k    <= 0;
         end
      end else if (m_k == 1) begin
         m_ir <= rom[m_pc];
         m_pc <= m_pc + 4'd1;
         m_k  <= 2;
      end else if (m_k + 1 == ilen(m_ir)) begin
         m_ret <= m_ret + 8'd1;
         if (m_ir == 6'b000001) begin
            m_halt <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_k    <= 0;
            m_busy <= bus.run;
         end
      end else begin
         m_k <= m_k + 1;
      end
   end

   // {instr_req, RF_ce, RF_addr, ALU_ce, op, A_ce, A_sel, halted, pc, retired}
   function automatic logic [22:0] model_vec();
      logic       req, rfce, aluce, ace, asel;
      logic [1:0] addr;
      logic [2:0] op;
      req = 0; rfce = 0; aluce = 0; ace = 0; asel = 0; addr = 0; op = 0;
      if (m_busy && m_k == 0) req = 1;
      if (m_busy && m_k == 2) begin
         if (m_ir[5]) begin
            aluce = 1; op = m_ir[4:2]; addr = m_ir[1:0];
         end else if (m_ir[5:4] == 2'b01) begin
            addr = m_ir[1:0];
            rfce = m_ir[3];
         end
      end
      if (m_busy && m_k == 3) begin
         ace = 1; asel = m_ir[5]; addr = m_ir[1:0];
         if (m_ir[5]) op = m_ir[4:2];
      end
      return {req, rfce, addr, aluce, op, ace, asel, m_halt, m_pc, m_ret};
   endfunction

   function automatic logic [22:0] dut_vec();
      return {bus.instr_req, bus.RF_ce, bus.RF_addr, bus.ALU_ce, bus.ALU_opcode_wire,
              bus.A_ce, bus.A_sel, bus.halted, bus.pc, bus.retired};
   endfunction

   // Per-cycle compare against the model
   logic cmp_en;
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [22:0] e, a;
         e = model_vec();
         a = dut_vec();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, a, e);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rom_fill(input logic [5:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   // Hold reset across one negedge, release away from any clock edge, realign
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      cmp_en = 1'b0;
      rst    = 1'b1;
      bus.run = 1'b0;
      rom_fill(6'b000000);
      #1 rst = 1'b0;
      #1 cmp_en = 1'b1;
      chk("reset_pc", int'(bus.pc), 0);
      chk("reset_halted", int'(bus.halted), 0);
      #10 rst = 1'b1;

      // LDA r0
      rom[0] = 6'b010100;
      do_reset();
      bus.run = 1'b1;
      step(1); chk("lda_instr_req_c1", int'(bus.instr_req), 1);
      step(3); chk("lda_A_ce_c4", int'(bus.A_ce), 1);
      chk("lda_A_sel", int'(bus.A_sel), 0);
      chk("lda_RF_addr", int'(bus.RF_addr), 0);
      step(1); chk("lda_pc", int'(bus.pc), 1);
      chk("lda_retired", int'(bus.retired), 1);

      // ALU op 3, r2
      bus.run = 1'b0;
      rom_fill(6'b000000);
      rom[0] = 6'b101110;
      do_reset();
      bus.run = 1'b1;
      step(3); chk("alu_ALU_ce", int'(bus.ALU_ce), 1);
      chk("alu_opcode", int'(bus.ALU_opcode_wire), 3);
      chk("alu_RF_addr", int'(bus.RF_addr), 2);
      step(1); chk("alu_A_ce", int'(bus.A_ce), 1);
      chk("alu_A_sel", int'(bus.A_sel), 1);

      // STA r1, NOP, HALT
      bus.run = 1'b0;
      rom_fill(6'b000000);
      rom[0] = 6'b011001;
      rom[2] = 6'b000001;
      do_reset();
      bus.run = 1'b1;
      begin
         int rfce_cnt, req_cnt;
         rfce_cnt = 0;
         for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus.RF_ce) begin
               rfce_cnt++;
               chk("sta_RF_addr", int'(bus.RF_addr), 1);
            end
         end
         chk("sta_RF_ce_cycles", rfce_cnt, 1);
         chk("halt_halted", int'(bus.halted), 1);
         chk("halt_retired", int'(bus.retired), 3);
         chk("halt_pc", int'(bus.pc), 3);
         req_cnt = 0;
         for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.instr_req) req_cnt++;
         end
         chk("halt_no_fetch", req_cnt, 0);
         chk("halt_pc_frozen", int'(bus.pc), 3);
      end

      // NOP-filled ROM: pc wrap and retired count
      bus.run = 1'b0;
      rom_fill(6'b000000);
      do_reset();
      bus.run = 1'b1;
      step(49);
      chk("nop_retired_48cyc", int'(bus.retired), 16);
      chk("nop_pc_wrapped", int'(bus.pc), 0);

      // run dropped during EXEC of an ALU op
      bus.run = 1'b0;
      rom_fill(6'b000000);
      rom[0] = 6'b100001;
      rom[1] = 6'b010110;
      do_reset();
      bus.run = 1'b1;
      step(3); chk("drop_exec_ALU_ce", int'(bus.ALU_ce), 1);
      bus.run = 1'b0;
      step(1); chk("drop_wb_A_ce", int'(bus.A_ce), 1);
      step(4); chk("drop_idle_no_req", int'(bus.instr_req), 0);
      chk("drop_idle_pc", int'(bus.pc), 1);
      chk("drop_idle_retired", int'(bus.retired), 1);
      bus.run = 1'b1;
      step(1); chk("resume_req", int'(bus.instr_req), 1);
      chk("resume_pc", int'(bus.pc), 1);

      // Reset pulsed during WB of LDA
      bus.run = 1'b0;
      rom_fill(6'b000000);
      rom[0] = 6'b010111;
      do_reset();
      bus.run = 1'b1;
      step(4); chk("rstwb_A_ce_before", int'(bus.A_ce), 1);
      #2 rst = 1'b0;
      #1 chk("rstwb_A_ce_async", int'(bus.A_ce), 0);
      chk("rstwb_pc", int'(bus.pc), 0);
      chk("rstwb_retired", int'(bus.retired), 0);
      bus.run = 1'b0;
      #1 rst = 1'b1;
      step(2); chk("rstwb_idle", int'(bus.instr_req), 0);

      // Randomized ROM, run toggling and reset pulses
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 199) == 0 || (bus.halted && $urandom_range(0, 19) == 0)) begin
            #2 rst = 1'b0;
            for (int i = 0; i < 16; i++) begin
               logic [5:0] v;
               v = 6'($urandom_range(0, 63));
               if (v == 6'b000001 && $urandom_range(0, 3) != 0) v = 6'b000000;
               rom[i] = v;
            end
            @(negedge clk);
            #2 rst = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
      end

      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
